pu_riscv_div: RTL and testbench
===============================

# pu_riscv_div

Iterative integer divider for the RV M-extension in the execute stage, covering DIV/DIVU/REM/REMU and, on RV64, DIVW/DIVUW/REMW/REMUW. It sits beside the multiplier and shares its operand, instruction, stall and bubble conventions. It computes one quotient bit per cycle on magnitudes, then applies sign correction. It stalls the pipeline until the result is registered for write-back.

## Interface
- XLEN, 64, datapath width (32 or 64)
- ILEN, 64, instruction width
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- ex_stall  in  1  execute stage stalled; a new operation is accepted only when low
- div_stall  out  1  registered; high while a division is in flight
- id_bubble  in  1  incoming instruction slot is a bubble
- id_instr  in  ILEN  incoming instruction; func7/func3/opcode decoded from [31:25]/[14:12]/[6:2]
- opA  in  XLEN  dividend
- opB  in  XLEN  divisor
- st_xlen  in  2  current XLEN state; RV32I disables the W forms
- div_bubble  out  1  registered; low for exactly one cycle when div_r is valid
- div_r  out  XLEN  registered result

## Operation
- Decode: is_div = DIV|DIVU|REM|REMU, or W form when st_xlen != RV32I.
- Accept in ST_IDLE on a rising edge with !ex_stall && !id_bubble && is_div. Registers:
  - op kind: quotient/remainder, signed/unsigned, W.
  - |dividend| and |divisor|. Unsigned ops pass operands through unchanged.
  - W forms: sext32 (signed) or zext32 (unsigned) of bits [31:0]. N = 32 for W forms, otherwise N = XLEN.
  - neg_q = sign(a) ^ sign(b) for signed ops; neg_r = sign(a).
  - Special flags: div0 (divisor == 0) and ovf (signed, dividend = most negative N-bit value, divisor = -1).
- Also on accept: div_stall <= 1, div_bubble <= 1, cnt <= N-1.
- FSM states:
  - ST_IDLE. Waits for accept.
  - ST_DIVIDE. Runs restoring division, one bit per cycle. Partial remainder is N+1 bits.
    - Shift in the next dividend bit and trial-subtract the divisor.
    - On a non-negative difference, keep the difference and set the quotient bit to 1.
    - Exits when cnt == 0.
  - ST_FINISH. Applies sign correction and selects the result, with special cases overriding:
    - div0: quotient = all ones; remainder = dividend.
    - ovf: quotient = dividend; remainder = 0.
    - Registers div_r, pulses div_bubble low, drops div_stall, returns to ST_IDLE.
- W results are sext32 of the 32-bit result.
- ex_stall and new instructions are ignored outside ST_IDLE.

## Timing
- Reset values: state ST_IDLE, cnt 0, div_stall 0, div_bubble 1, div_r 0.
- Normal latency, counting edges after the accept edge:
  - edges 1..N iterate;
  - edge N+1 registers div_r, sets div_bubble = 0 and div_stall = 0.
- div_bubble returns to 1 on the next edge.
- A back-to-back divide can be accepted on edge N+2 at the earliest.
- Reset asserted mid-operation returns to ST_IDLE immediately:
  - div_stall 0, div_bubble 1;
  - the partial result is discarded and no write-back occurs.
- Accept with is_div low, or with id_bubble high, leaves all outputs unchanged except div_bubble, which holds 1.

## Configuration
- PU_RISCV_DIV_EARLY_OUT_EN defined:
  - div0 or ovf detected at accept jumps ST_IDLE to ST_FINISH directly.
  - Result is registered on edge 2 after accept.
- Undefined:
  - Special cases traverse all N iterations (latency N+1).
  - Results are identical in both builds; only latency differs.

## Structure
- pu_riscv_verilog_pkg holds:
  - instruction patterns DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW (casex-compatible {func7, func3, opcode[6:2]});
  - RV32I;
  - the shared sext32/twos function style.
- ST_IDLE, ST_DIVIDE and ST_FINISH are local 2-bit constants.
- One sub-module is natural: pu_riscv_div_step, the combinational shift/trial-subtract of one quotient bit. It is parameterized on width and instantiated once.

## Test plan
- DIVU 100/7, XLEN=64:
  - div_r = 14;
  - div_stall high for edges 1..64;
  - div_bubble low for one cycle after edge 65.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 7/2 -> 1.
- DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 5/0 -> 5.
  - Latency is 2 edges with PU_RISCV_DIV_EARLY_OUT_EN, 65 without.
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
- DIVW opA = 0x0000_0001_8000_0000, opB = 0xFFFF_FFFF_FFFF_FFFF:
  - div_r = 0xFFFF_FFFF_8000_0000, result on edge 33 (without the macro).
  - With st_xlen = RV32I, the same instruction is not accepted and div_stall stays 0.
- Reset mid-operation:
  - rstn low at edge 10 of a DIVU -> div_stall 0, div_bubble 1 immediately.
  - The next DIVU 81/9 returns 9 with full latency.

Source files
------------

// File: rtl/pu_riscv_verilog_pkg.sv
// Shared RV decode constants and operand helpers for the execute-stage units.
package pu_riscv_verilog_pkg;

   localparam logic [1:0] RV32I = 2'b01;

   localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_OP32     = 5'b01110;

   // Patterns are {func7, func3, opcode[6:2]}
   localparam logic [14:0] DIV   = {FUNC7_MULDIV, 3'b100, OPC_OP};
   localparam logic [14:0] DIVU  = {FUNC7_MULDIV, 3'b101, OPC_OP};
   localparam logic [14:0] REM   = {FUNC7_MULDIV, 3'b110, OPC_OP};
   localparam logic [14:0] REMU  = {FUNC7_MULDIV, 3'b111, OPC_OP};
   localparam logic [14:0] DIVW  = {FUNC7_MULDIV, 3'b100, OPC_OP32};
   localparam logic [14:0] DIVUW = {FUNC7_MULDIV, 3'b101, OPC_OP32};
   localparam logic [14:0] REMW  = {FUNC7_MULDIV, 3'b110, OPC_OP32};
   localparam logic [14:0] REMUW = {FUNC7_MULDIV, 3'b111, OPC_OP32};

   function automatic logic [63:0] sext32(input logic [31:0] op);
      return {{32{op[31]}}, op};
   endfunction

   function automatic logic [63:0] zext32(input logic [31:0] op);
      return {32'h0000_0000, op};
   endfunction

   function automatic logic [63:0] twos(input logic [63:0] op);
      return ~op + 64'd1;
   endfunction

endpackage

// File: rtl/pu_riscv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module pu_riscv_div_step #(
   parameter int W = 64
) (
   input  logic [W:0]   rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] dsr,
   output logic [W:0]   rem_nxt,
   output logic [W-1:0] quo_nxt
);

   logic [W+1:0] shf_s;
   logic [W+1:0] dif_s;

   // Trial subtraction; the extra top bit of dif_s is the borrow
   always_comb begin
      shf_s = {rem, quo[W-1]};
      dif_s = shf_s - {2'b00, dsr};
      if (!dif_s[W+1]) begin
         rem_nxt = dif_s[W:0];
         quo_nxt = {quo[W-2:0], 1'b1};
      end else begin
         rem_nxt = shf_s[W:0];
         quo_nxt = {quo[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/pu_riscv_div.sv
// Iterative RV M-extension divider (DIV/DIVU/REM/REMU and W forms), one quotient bit per cycle.
// Optional PU_RISCV_DIV_EARLY_OUT_EN: divide-by-zero and overflow skip the iterations.
module pu_riscv_div
   import pu_riscv_verilog_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int ILEN = 64
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            ex_stall,
   output logic            div_stall,
   input  logic            id_bubble,
   input  logic [ILEN-1:0] id_instr,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   input  logic [1:0]      st_xlen,
   output logic            div_bubble,
   output logic [XLEN-1:0] div_r
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_X   = {CW{1'b1}};
   localparam logic [CW-1:0]   CNT_W   = CW'(5'd31);
   localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] MIN_X   = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [XLEN:0]   rem_r, rem_s, rem_step_s;
   logic [XLEN-1:0] quo_r, quo_s, quo_step_s;
   logic [XLEN-1:0] dsr_r, dsr_s;
   logic [XLEN-1:0] dvd_r, dvd_s;
   logic            is_rem_r, is_rem_s, is_w_r, is_w_s;
   logic            neg_q_r, neg_q_s, neg_r_r, neg_r_s;
   logic            div0_r, div0_s, ovf_r, ovf_s;
   logic            stall_s, bubble_s;
   logic [XLEN-1:0] res_s;

   logic [14:0]     pat_s;
   logic            dec_div_s, dec_rem_s, dec_uns_s, dec_w_s;
   logic [63:0]     a_x64_s, b_x64_s, a_neg64_s, b_neg64_s;
   logic [XLEN-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, quo_ld_s;
   logic            sgn_a_s, sgn_b_s, spec_div0_s, spec_ovf_s;
   logic [CW-1:0]   cnt_ld_s;

   logic [63:0]     q_neg64_s, r_neg64_s, res64_s;
   logic [XLEN-1:0] q_fix_s, r_fix_s, q_sel_s, r_sel_s, pick_s, fin_s;
   logic            unused_s;

   // Only the func7/func3/opcode fields participate in decode
   assign unused_s = ^id_instr;

   // Instruction decode; W forms are illegal while running RV32I
   always_comb begin
      pat_s     = {id_instr[31:25], id_instr[14:12], id_instr[6:2]};
      dec_div_s = 1'b0;
      dec_rem_s = 1'b0;
      dec_uns_s = 1'b0;
      dec_w_s   = 1'b0;
      case (pat_s)
         DIV:   dec_div_s = 1'b1;
         DIVU:  begin dec_div_s = 1'b1; dec_uns_s = 1'b1; end
         REM:   begin dec_div_s = 1'b1; dec_rem_s = 1'b1; end
         REMU:  begin dec_div_s = 1'b1; dec_rem_s = 1'b1; dec_uns_s = 1'b1; end
         DIVW:  begin dec_div_s = (st_xlen != RV32I); dec_w_s = 1'b1; end
         DIVUW: begin dec_div_s = (st_xlen != RV32I); dec_w_s = 1'b1; dec_uns_s = 1'b1; end
         REMW:  begin dec_div_s = (st_xlen != RV32I); dec_w_s = 1'b1; dec_rem_s = 1'b1; end
         REMUW: begin
            dec_div_s = (st_xlen != RV32I);
            dec_w_s   = 1'b1;
            dec_rem_s = 1'b1;
            dec_uns_s = 1'b1;
         end
         default: dec_div_s = 1'b0;
      endcase
   end

   // Operand extension, magnitudes, sign and special-case detection at accept
   always_comb begin
      if (dec_w_s) begin
         if (dec_uns_s) begin
            a_x64_s = zext32(opA[31:0]);
            b_x64_s = zext32(opB[31:0]);
         end else begin
            a_x64_s = sext32(opA[31:0]);
            b_x64_s = sext32(opB[31:0]);
         end
      end else begin
         a_x64_s = 64'(opA);
         b_x64_s = 64'(opB);
      end
      a_ext_s   = a_x64_s[XLEN-1:0];
      b_ext_s   = b_x64_s[XLEN-1:0];
      sgn_a_s   = ~dec_uns_s & a_ext_s[XLEN-1];
      sgn_b_s   = ~dec_uns_s & b_ext_s[XLEN-1];
      a_neg64_s = twos(a_x64_s);
      b_neg64_s = twos(b_x64_s);
      a_mag_s   = sgn_a_s ? a_neg64_s[XLEN-1:0] : a_ext_s;
      b_mag_s   = sgn_b_s ? b_neg64_s[XLEN-1:0] : b_ext_s;
      spec_div0_s = (b_ext_s == {XLEN{1'b0}});
      if (dec_w_s) begin
         spec_ovf_s = ~dec_uns_s & (a_ext_s[31:0] == 32'h8000_0000) &
                      (b_ext_s[31:0] == 32'hFFFF_FFFF);
         // Park the 32-bit dividend at the top so the shared datapath shifts it out first
         quo_ld_s   = a_mag_s << (XLEN - 32);
         cnt_ld_s   = CNT_W;
      end else begin
         spec_ovf_s = ~dec_uns_s & (a_ext_s == MIN_X) & (b_ext_s == {XLEN{1'b1}});
         quo_ld_s   = a_mag_s;
         cnt_ld_s   = CNT_X;
      end
   end

   pu_riscv_div_step #(.W(XLEN)) u_step (
      .rem     (rem_r),
      .quo     (quo_r),
      .dsr     (dsr_r),
      .rem_nxt (rem_step_s),
      .quo_nxt (quo_step_s)
   );

   // Sign correction and special-case result selection
   always_comb begin
      q_neg64_s = twos(64'(quo_r));
      r_neg64_s = twos(64'(rem_r[XLEN-1:0]));
      q_fix_s   = neg_q_r ? q_neg64_s[XLEN-1:0] : quo_r;
      r_fix_s   = neg_r_r ? r_neg64_s[XLEN-1:0] : rem_r[XLEN-1:0];
      if (div0_r) begin
         q_sel_s = {XLEN{1'b1}};
         r_sel_s = dvd_r;
      end else if (ovf_r) begin
         q_sel_s = dvd_r;
         r_sel_s = {XLEN{1'b0}};
      end else begin
         q_sel_s = q_fix_s;
         r_sel_s = r_fix_s;
      end
      pick_s  = is_rem_r ? r_sel_s : q_sel_s;
      res64_s = sext32(pick_s[31:0]);
      fin_s   = is_w_r ? res64_s[XLEN-1:0] : pick_s;
   end

   // Next-state and next-output logic
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      rem_s    = rem_r;
      quo_s    = quo_r;
      dsr_s    = dsr_r;
      dvd_s    = dvd_r;
      is_rem_s = is_rem_r;
      is_w_s   = is_w_r;
      neg_q_s  = neg_q_r;
      neg_r_s  = neg_r_r;
      div0_s   = div0_r;
      ovf_s    = ovf_r;
      stall_s  = div_stall;
      bubble_s = 1'b1;
      res_s    = div_r;
      case (state_r)
         ST_IDLE: begin
            if (!ex_stall && !id_bubble && dec_div_s) begin
               rem_s    = {(XLEN+1){1'b0}};
               quo_s    = quo_ld_s;
               dsr_s    = b_mag_s;
               dvd_s    = a_ext_s;
               is_rem_s = dec_rem_s;
               is_w_s   = dec_w_s;
               neg_q_s  = sgn_a_s ^ sgn_b_s;
               neg_r_s  = sgn_a_s;
               div0_s   = spec_div0_s;
               ovf_s    = spec_ovf_s;
               stall_s  = 1'b1;
`ifdef PU_RISCV_DIV_EARLY_OUT_EN
               if (spec_div0_s || spec_ovf_s) begin
                  state_s = ST_FINISH;
                  cnt_s   = CNT_ONE;
               end else begin
                  state_s = ST_DIVIDE;
                  cnt_s   = cnt_ld_s;
               end
`else
               state_s = ST_DIVIDE;
               cnt_s   = cnt_ld_s;
`endif
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DIVIDE: begin
            rem_s = rem_step_s;
            quo_s = quo_step_s;
            if (cnt_r == {CW{1'b0}}) begin
               state_s = ST_FINISH;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_FINISH: begin
            // Non-zero count only on the early-out path, which holds here one extra cycle
            if (cnt_r != {CW{1'b0}}) begin
               cnt_s = cnt_r - CNT_ONE;
            end else begin
               res_s    = fin_s;
               bubble_s = 1'b0;
               stall_s  = 1'b0;
               state_s  = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            stall_s = 1'b0;
            cnt_s   = {CW{1'b0}};
         end
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CW{1'b0}};
         rem_r      <= {(XLEN+1){1'b0}};
         quo_r      <= {XLEN{1'b0}};
         dsr_r      <= {XLEN{1'b0}};
         dvd_r      <= {XLEN{1'b0}};
         is_rem_r   <= 1'b0;
         is_w_r     <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         div0_r     <= 1'b0;
         ovf_r      <= 1'b0;
         div_stall  <= 1'b0;
         div_bubble <= 1'b1;
         div_r      <= {XLEN{1'b0}};
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         rem_r      <= rem_s;
         quo_r      <= quo_s;
         dsr_r      <= dsr_s;
         dvd_r      <= dvd_s;
         is_rem_r   <= is_rem_s;
         is_w_r     <= is_w_s;
         neg_q_r    <= neg_q_s;
         neg_r_r    <= neg_r_s;
         div0_r     <= div0_s;
         ovf_r      <= ovf_s;
         div_stall  <= stall_s;
         div_bubble <= bubble_s;
         div_r      <= res_s;
      end
   end

endmodule

// File: tb/tb_pu_riscv_div.sv
// Self-checking bench for pu_riscv_div (XLEN=64): directed cases plus randomized ops
// against an arithmetic reference model.
module tb_pu_riscv_div;

   logic        clk;
   logic        rstn;
   logic        ex_stall;
   logic        div_stall;
   logic        id_bubble;
   logic [63:0] id_instr;
   logic [63:0] opA;
   logic [63:0] opB;
   logic [1:0]  st_xlen;
   logic        div_bubble;
   logic [63:0] div_r;

   int checks = 0;
   int errors = 0;

   pu_riscv_div #(.XLEN(64), .ILEN(64)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .ex_stall   (ex_stall),
      .div_stall  (div_stall),
      .id_bubble  (id_bubble),
      .id_instr   (id_instr),
      .opA        (opA),
      .opB        (opB),
      .st_xlen    (st_xlen),
      .div_bubble (div_bubble),
      .div_r      (div_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // op = {w, rem, unsigned}
   localparam logic [2:0] O_DIV = 3'b000, O_DIVU = 3'b001, O_REM = 3'b010, O_REMU = 3'b011;
   localparam logic [2:0] O_DIVW = 3'b100;

   function automatic logic [63:0] mk(input logic [2:0] op);
      logic [6:0] opc;
      opc = op[2] ? 7'b0111011 : 7'b0110011;
      return {32'h0, 7'b0000001, 10'h0, 1'b1, op[1], op[0], 5'h0, opc};
   endfunction

   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, r32;
      logic [63:0] r;
      int          sa32, sb32;
      longint      sa, sb;
      if (op[2]) begin
         a32 = a[31:0];
         b32 = b[31:0];
         if (b32 == 32'd0) r32 = op[1] ? a32 : 32'hFFFF_FFFF;
         else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a32;
         else if (op[0]) r32 = op[1] ? a32 % b32 : a32 / b32;
         else begin
            sa32 = a32;
            sb32 = b32;
            r32 = op[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
         end
         r = {{32{r32[31]}}, r32};
      end else begin
         if (b == 64'd0) r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
         else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = op[1] ? 64'd0 : a;
         else if (op[0]) r = op[1] ? a % b : a / b;
         else begin
            sa = a;
            sb = b;
            r = op[1] ? 64'(sa % sb) : 64'(sa / sb);
         end
      end
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      bit special;
      if (op[2]) special = (b[31:0] == 32'd0) ||
                           (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      else special = (b == 64'd0) ||
                     (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef PU_RISCV_DIV_EARLY_OUT_EN
      if (special) return 2;
`else
      if (special) return op[2] ? 33 : 65;
`endif
      return op[2] ? 33 : 65;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_div(input string tag, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input bit noisy);
      int lat;
      bit got;
      bit stall_ok;
      got = 1'b0;
      lat = 0;
      stall_ok = 1'b1;
      @(negedge clk);
      id_instr = mk(op); opA = a; opB = b; id_bubble = 1'b0; ex_stall = 1'b0;
      @(posedge clk); #1;
      id_bubble = 1'b1;
      chk({tag, "_acc_stall"}, 64'(div_stall), 64'd1);
      chk({tag, "_acc_bub"}, 64'(div_bubble), 64'd1);
      for (int e = 1; e <= 200 && !got; e++) begin
         if (noisy) begin
            id_instr = mk(3'($urandom_range(0, 7)));
            opA = {$urandom, $urandom};
            opB = {$urandom, $urandom};
            id_bubble = 1'b0;
            ex_stall = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         if (div_bubble === 1'b0) begin
            got = 1'b1;
            lat = e;
         end else if (div_stall !== 1'b1) begin
            stall_ok = 1'b0;
         end
      end
      id_bubble = 1'b1;
      ex_stall = 1'b0;
      chk({tag, "_done"}, 64'(got), 64'd1);
      chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, a, b)));
      chk({tag, "_res"}, div_r, ref_res(op, a, b));
      chk({tag, "_stall_low"}, 64'(div_stall), 64'd0);
      chk({tag, "_stall_held"}, 64'(stall_ok), 64'd1);
      @(posedge clk); #1;
      chk({tag, "_bub_back"}, 64'(div_bubble), 64'd1);
   endtask

   task automatic no_accept(input string tag, input logic [63:0] instr, input logic bub,
                            input logic stl, input logic [1:0] xl);
      logic [63:0] prev;
      prev = div_r;
      @(negedge clk);
      id_instr = instr; opA = 64'd100; opB = 64'd7; id_bubble = bub; ex_stall = stl; st_xlen = xl;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk({tag, "_stall"}, 64'(div_stall), 64'd0);
         chk({tag, "_bub"}, 64'(div_bubble), 64'd1);
      end
      chk({tag, "_res_hold"}, div_r, prev);
      id_bubble = 1'b1; ex_stall = 1'b0; st_xlen = 2'b10;
   endtask

   initial begin
      logic [2:0]  op;
      logic [63:0] a, b;
      int          sel, bad;
      rstn = 1'b0; ex_stall = 1'b0; id_bubble = 1'b1; id_instr = 64'd0;
      opA = 64'd0; opB = 64'd0; st_xlen = 2'b10;
      #12;
      chk("rst_stall", 64'(div_stall), 64'd0);
      chk("rst_bub", 64'(div_bubble), 64'd1);
      chk("rst_res", div_r, 64'd0);
      @(negedge clk); rstn = 1'b1;

      do_div("divu_100_7", O_DIVU, 64'd100, 64'd7, 1'b0);
      chk("divu_100_7_val", div_r, 64'd14);
      do_div("div_m7_2", O_DIV, -64'sd7, 64'd2, 1'b0);
      chk("div_m7_2_val", div_r, 64'hFFFF_FFFF_FFFF_FFFD);
      do_div("rem_m7_2", O_REM, -64'sd7, 64'd2, 1'b0);
      chk("rem_m7_2_val", div_r, 64'hFFFF_FFFF_FFFF_FFFF);
      do_div("remu_7_2", O_REMU, 64'd7, 64'd2, 1'b0);
      chk("remu_7_2_val", div_r, 64'd1);
      do_div("div_5_0", O_DIV, 64'd5, 64'd0, 1'b0);
      chk("div_5_0_val", div_r, 64'hFFFF_FFFF_FFFF_FFFF);
      do_div("remu_5_0", O_REMU, 64'd5, 64'd0, 1'b0);
      chk("remu_5_0_val", div_r, 64'd5);
      do_div("div_ovf", O_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      chk("div_ovf_val", div_r, 64'h8000_0000_0000_0000);
      do_div("rem_ovf", O_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      chk("rem_ovf_val", div_r, 64'd0);
      do_div("divw_ovf", O_DIVW, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      chk("divw_ovf_val", div_r, 64'hFFFF_FFFF_8000_0000);

      no_accept("divw_rv32", mk(O_DIVW), 1'b0, 1'b0, 2'b01);
      no_accept("bubble_in", mk(O_DIVU), 1'b1, 1'b0, 2'b10);
      no_accept("ex_stall", mk(O_DIVU), 1'b0, 1'b1, 2'b10);
      no_accept("not_div", 64'h0000_0000_0000_0033, 1'b0, 1'b0, 2'b10);

      do_div("noisy_divu", O_DIVU, 64'd1000, 64'd33, 1'b1);

      // Reset while a divide is in flight
      @(negedge clk);
      id_instr = mk(O_DIVU); opA = 64'hFFFF_0000_1234_5678; opB = 64'd3; id_bubble = 1'b0;
      @(posedge clk); #1;
      id_bubble = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst_stall", 64'(div_stall), 64'd0);
      chk("midrst_bub", 64'(div_bubble), 64'd1);
      chk("midrst_res", div_r, 64'd0);
      @(negedge clk); rstn = 1'b1;
      bad = 0;
      for (int k = 0; k < 70; k++) begin
         @(posedge clk); #1;
         if (div_bubble !== 1'b1 || div_stall !== 1'b0) bad++;
      end
      chk("midrst_no_wb", 64'(bad), 64'd0);
      do_div("divu_81_9", O_DIVU, 64'd81, 64'd9, 1'b0);
      chk("divu_81_9_val", div_r, 64'd9);

      for (int i = 0; i < 30; i++) begin
         op  = 3'($urandom_range(0, 7));
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 64'd0;
         else if (sel == 1) begin
            b = 64'hFFFF_FFFF_FFFF_FFFF;
            a = op[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
         end
         else if (sel == 2) b = 64'($urandom_range(1, 15)) ^ (op[0] ? 64'd0 : {64{b[63]}});
         else if (sel == 3) a = 64'($urandom_range(0, 200));
         do_div($sformatf("rnd%0d", i), op, a, b, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
